rx_info_phy: RTL and testbench
==============================

RX_INFO_PHY -- requirements
Module: rx_info_phy

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops on rx (legal 2..3).
REQ-002 clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx  input  1  serial line from the transmitter; idles high.
REQ-005 tbit_period  input  20  clock cycles per bit; legal range 4..2^20-1.
REQ-006 data_rx  output  8  last correctly framed byte.
REQ-007 done_rx  output  1  one-cycle pulse: data_rx updated with a valid byte.
REQ-008 err_frame  output  1  one-cycle pulse: frame rejected (stop bit low).
REQ-009 busy_rx  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-010 Frame format: 1 start bit (low), 8 data bits MSB first (bit 7 first), 2 stop bits (high), each bit tbit_period cycles long.
REQ-011 rx passes through SYNC_STAGES flops; only the synchronized value rx_s is used internally.
REQ-012 Start detect: in IDLE, rx_s_prev=1 and rx_s=0 moves to START; the counter clears to 0 and tbit_period is latched into per_l.
REQ-013 per_l holds for the whole frame; tbit_period changes mid-frame have no effect until the next start.
REQ-014 Counter cnt is 20 bits and increments every cycle outside IDLE/DONE/ERR.
  - Sample point in START: cnt == (per_l>>1)-1.
  - Sample point in all later states: cnt == per_l-1.
  - cnt returns to 0 on every sample point.
REQ-015 START sample: rx_s=0 -> S7; rx_s=1 -> IDLE (glitch rejected), with no pulse on any output.
REQ-016 Data states S7..S0: at each sample point, rx_s is stored into shift bit 7..0 respectively, then the FSM moves to the next state; S0 is followed by STOP1.
REQ-017 STOP1 sample: rx_s=1 -> STOP2; rx_s=0 -> ERR.
REQ-018 STOP2 sample: rx_s=1 -> DONE; rx_s=0 -> ERR.
REQ-019 DONE (one cycle): data_rx <= shift register, done_rx=1, then IDLE.
REQ-020 ERR (one cycle): err_frame=1, data_rx unchanged, then IDLE.
REQ-021 After ERR, rearm requires a new 1->0 edge on rx_s; a line held low does not retrigger.
REQ-022 State encoding: IDLE, START, S7, S6, S5, S4, S3, S2, S1, S0, STOP1, STOP2, DONE, ERR; unreachable codes go to IDLE.
REQ-023 done_rx and err_frame are never asserted in the same cycle.
REQ-024 Latency: done_rx asserts SYNC_STAGES + 1 + (per_l>>1) + 10*per_l cycles after the rx falling edge, ±1 cycle.
REQ-025 Back-to-back frames: the receiver is in IDLE before the transmitter's next start bit, including a frame starting one cycle after the transmitter's second stop bit ends.

Reset
REQ-026 While rst=1:
  - state = IDLE
  - cnt = 0
  - per_l = 0
  - shift register = 0x00
  - data_rx = 0x00
  - done_rx = 0
  - err_frame = 0
  - busy_rx = 0
  - synchronizer flops and rx_s_prev = 1
REQ-027 Reset asserted mid-frame discards the partial byte; after release the receiver waits for a fresh falling edge.

Verification
REQ-028 tbit_period=8, send 0xA5 (10100101) with 2 stop bits -> one done_rx pulse, data_rx=0xA5, no err_frame.
REQ-029 tbit_period=8, send frames 0x00 then 0xFF back-to-back with no idle gap -> two done_rx pulses, data_rx=0x00 then 0xFF.
REQ-030 tbit_period=8, send 0x3C with STOP2 driven low -> one err_frame pulse, no done_rx, data_rx keeps its previous value.
REQ-031 tbit_period=8, 2-cycle low glitch on an idle line -> no done_rx, no err_frame, busy_rx back low within 8 cycles.
REQ-032 tbit_period=16, assert rst during bit S4 of a frame, release, then send 0x81 -> data_rx=0x81 and exactly one done_rx.
REQ-033 tbit_period=8 at start, changed to 20 during S6, send 0x5A -> data_rx=0x5A (latched period used).

Source files
------------

// File: rtl/rx_info_phy.sv
// Asynchronous serial byte receiver: 1 start bit, 8 data bits MSB first, 2 stop bits.
// Bit period is latched at start-bit detection and held for the whole frame.
module rx_info_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        rx,
  input  logic [19:0] tbit_period,
  output logic [7:0]  data_rx,
  output logic        done_rx,
  output logic        err_frame,
  output logic        busy_rx
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    S7    = 4'd2,
    S6    = 4'd3,
    S5    = 4'd4,
    S4    = 4'd5,
    S3    = 4'd6,
    S2    = 4'd7,
    S1    = 4'd8,
    S0    = 4'd9,
    STOP1 = 4'd10,
    STOP2 = 4'd11,
    DONE  = 4'd12,
    ERR   = 4'd13
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [19:0]            r_cnt;
  logic [19:0]            r_per;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   w_rx_s;
  logic                   w_sample;
  logic [19:0]            w_half;
  logic [19:0]            w_full;
  logic [2:0]             w_bit_idx;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_half    = (r_per >> 1) - 20'd1;
  assign w_full    = r_per - 20'd1;
  assign w_bit_idx = 3'(4'd9 - r_state);

  // Synchronizer resets to the idle-high line level so release never looks like a start edge.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
      r_rx_prev <= w_rx_s;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rx_prev && !w_rx_s) w_next = START;
      end
      START: begin
        if (r_cnt == w_half) begin
          w_sample = 1'b1;
          w_next   = w_rx_s ? IDLE : S7;
        end
      end
      S7, S6, S5, S4, S3, S2, S1, S0: begin
        if (r_cnt == w_full) begin
          w_sample = 1'b1;
          w_next   = state_t'(r_state + 4'd1);
        end
      end
      STOP1: begin
        if (r_cnt == w_full) begin
          w_sample = 1'b1;
          w_next   = w_rx_s ? STOP2 : ERR;
        end
      end
      STOP2: begin
        if (r_cnt == w_full) begin
          w_sample = 1'b1;
          w_next   = w_rx_s ? DONE : ERR;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_per   <= '0;
      r_shift <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (w_next == START) r_per <= tbit_period;
      end else if (r_state == DONE || r_state == ERR) begin
        r_cnt <= '0;
      end else if (w_sample) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
      if (w_sample && r_state >= S7 && r_state <= S0) r_shift[w_bit_idx] <= w_rx_s;
      // Publish the byte on entry to DONE so it is already stable while done_rx is high.
      if (r_state == STOP2 && w_next == DONE) r_data <= r_shift;
    end
  end

  assign data_rx   = r_data;
  assign done_rx   = (r_state == DONE);
  assign err_frame = (r_state == ERR);
  assign busy_rx   = (r_state != IDLE);

endmodule

// File: tb/tb_rx_info_phy.sv
// Scoreboard bench for rx_info_phy: directed frames push expected events,
// a negedge monitor pops and checks each done_rx/err_frame pulse.
module tb_rx_info_phy;

  typedef struct {
    logic       isErr;
    logic [7:0] data;
    int         startCyc;
    int         expLat;
  } item_t;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        rx;
  logic [19:0] tbit_period;
  logic [7:0]  data_rx;
  logic        done_rx;
  logic        err_frame;
  logic        busy_rx;

  int    cycle = 0;
  int    nChecks = 0;
  int    nFails = 0;
  item_t expQ[$];

  rx_info_phy #(.SYNC_STAGES(2)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .rx          (rx),
    .tbit_period (tbit_period),
    .data_rx     (data_rx),
    .done_rx     (done_rx),
    .err_frame   (err_frame),
    .busy_rx     (busy_rx)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cycle++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Drives the first nBits of a frame; optionally changes tbit_period as bit chgIdx begins.
  task automatic sendFrame(input logic [7:0] data, input int len, input logic stop2,
                           input int nBits, input int chgIdx, input logic [19:0] chgPer);
    logic bits [11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[7-i];
    bits[9]  = 1'b1;
    bits[10] = stop2;
    for (int i = 0; i < nBits; i++) begin
      if (i == chgIdx) tbit_period = chgPer;
      rx = bits[i];
      repeat (len) @(negedge clk_sys);
    end
    rx = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int len, input logic stop2,
                               input logic expErr, input logic [7:0] expData, input int expLat,
                               input int chgIdx, input logic [19:0] chgPer);
    item_t it;
    it.isErr    = expErr;
    it.data     = expData;
    it.startCyc = cycle;
    it.expLat   = expLat;
    expQ.push_back(it);
    sendFrame(data, len, stop2, 11, chgIdx, chgPer);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk_sys) begin
    if (!rst && (done_rx || err_frame)) begin
      checkOutput("done/err exclusive", int'(done_rx && err_frame), 0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse (done_rx)", int'(done_rx), 0);
      end else begin
        item_t it;
        int lat;
        it  = expQ.pop_front();
        lat = cycle - it.startCyc;
        checkOutput("pulse kind err_frame", int'(err_frame), int'(it.isErr));
        checkOutput("data_rx", int'(data_rx), int'(it.data));
        if (lat < it.expLat - 1 || lat > it.expLat + 1)
          checkOutput("latency", lat, it.expLat);
        else
          checkOutput("latency", it.expLat, it.expLat);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCnt;
    rst = 1'b1;
    rx = 1'b1;
    tbit_period = 20'd8;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset data_rx", int'(data_rx), 0);
    checkOutput("reset done_rx", int'(done_rx), 0);
    checkOutput("reset err_frame", int'(err_frame), 0);
    checkOutput("reset busy_rx", int'(busy_rx), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);
    checkOutput("idle busy_rx", int'(busy_rx), 0);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 8, 1'b1, 1'b0, 8'hA5, 87, -1, 20'd0);
    repeat (10) @(negedge clk_sys);

    $display("[TB] back-to-back 0x00 / 0xFF");
    applyStimulus(8'h00, 8, 1'b1, 1'b0, 8'h00, 87, -1, 20'd0);
    applyStimulus(8'hFF, 8, 1'b1, 1'b0, 8'hFF, 87, -1, 20'd0);
    repeat (10) @(negedge clk_sys);

    $display("[TB] stop2 low on 0x3C");
    applyStimulus(8'h3C, 8, 1'b0, 1'b1, 8'hFF, 87, -1, 20'd0);
    repeat (10) @(negedge clk_sys);
    checkOutput("data_rx kept after err", int'(data_rx), 'hFF);

    $display("[TB] 2-cycle glitch");
    busyCnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) rx = 1'b1;
      @(negedge clk_sys);
      if (busy_rx) busyCnt++;
    end
    checkOutput("glitch busy_rx seen and short", int'(busyCnt > 0 && busyCnt <= 8), 1);
    checkOutput("glitch busy_rx low after", int'(busy_rx), 0);

    $display("[TB] reset during S4, then 0x81");
    tbit_period = 20'd16;
    sendFrame(8'h3C, 16, 1'b1, 4, -1, 20'd0);
    repeat (8) @(negedge clk_sys);
    checkOutput("busy_rx mid-frame", int'(busy_rx), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput("mid-frame reset busy_rx", int'(busy_rx), 0);
    checkOutput("mid-frame reset data_rx", int'(data_rx), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk_sys);
    applyStimulus(8'h81, 16, 1'b1, 1'b0, 8'h81, 171, -1, 20'd0);
    repeat (10) @(negedge clk_sys);

    $display("[TB] period change mid-frame, 0x5A");
    tbit_period = 20'd8;
    applyStimulus(8'h5A, 8, 1'b1, 1'b0, 8'h5A, 87, 2, 20'd20);
    repeat (10) @(negedge clk_sys);

    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk_sys);
    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("final busy_rx", int'(busy_rx), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
